// File: rtl/yarp_writeback_if.sv
// Signal bundle between the writeback stage and its neighbours: the load-issue and
// load-response paths, the ALU result path, the register-file write port and the decode hazard query.
interface yarp_writeback_if;
  // Handshake rule: a transfer happens on a rising clk edge where valid and ready
  // are both 1. ld_rsp_valid_i has no ready and is always taken.
  logic        ld_issue_valid_i;
  logic        ld_issue_ready_o;
  logic [4:0]  ld_issue_rd_i;
  logic [2:0]  ld_issue_funct3_i;
  logic [1:0]  ld_issue_offset_i;
  logic        ld_rsp_valid_i;
  logic [31:0] ld_rsp_data_i;
  logic        alu_valid_i;
  logic        alu_ready_o;
  logic [4:0]  alu_rd_i;
  logic [31:0] alu_data_i;
  logic [4:0]  rd_addr_o;
  logic        wr_en_o;
  logic [31:0] wr_data_o;
  logic [4:0]  rs1_addr_i;
  logic [4:0]  rs2_addr_i;
  logic        hazard_o;

  modport slave (
    input  ld_issue_valid_i, ld_issue_rd_i, ld_issue_funct3_i, ld_issue_offset_i,
    input  ld_rsp_valid_i, ld_rsp_data_i,
    input  alu_valid_i, alu_rd_i, alu_data_i,
    input  rs1_addr_i, rs2_addr_i,
    output ld_issue_ready_o, alu_ready_o,
    output rd_addr_o, wr_en_o, wr_data_o, hazard_o
  );

  modport master (
    output ld_issue_valid_i, ld_issue_rd_i, ld_issue_funct3_i, ld_issue_offset_i,
    output ld_rsp_valid_i, ld_rsp_data_i,
    output alu_valid_i, alu_rd_i, alu_data_i,
    output rs1_addr_i, rs2_addr_i,
    input  ld_issue_ready_o, alu_ready_o,
    input  rd_addr_o, wr_en_o, wr_data_o, hazard_o
  );
endinterface

// File: rtl/yarp_writeback.sv
// Retire stage: merges ALU results and in-order load responses into one register-file
// write port, extends loaded bytes/halves, and tracks registers awaiting load data.
module yarp_writeback #(
  parameter int LD_DEPTH = 2
) (
  input  logic clk,
  input  logic reset_n,
  yarp_writeback_if.slave wb
);

  localparam int PTR_W = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
  localparam int CNT_W = $clog2(LD_DEPTH + 1);

  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [1:0] offset;
  } ld_meta_t;

  ld_meta_t          fifo_q [LD_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [31:0]       busy_q;
  logic [31:0]       busy_next;

  logic              wr_en_q;
  logic              wr_is_load_q;
  logic [4:0]        rd_addr_q;
  logic [31:0]       wr_data_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic              issue_rd_busy;
  logic              ld_push;
  logic              ld_pop;
  logic              alu_accept;
  ld_meta_t          issue_meta;
  ld_meta_t          head;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_result;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(LD_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  function automatic logic rs_hazard(input logic [4:0] rs,
                                     input logic [31:0] busy,
                                     input logic we,
                                     input logic [4:0] wr_rd);
    return (rs != 5'd0) && (busy[rs] || (we && (wr_rd == rs)));
  endfunction

  assign fifo_full     = (count_q == CNT_W'(LD_DEPTH));
  assign fifo_empty    = (count_q == '0);
  assign issue_rd_busy = busy_q[wb.ld_issue_rd_i] && (wb.ld_issue_rd_i != 5'd0);

  // Readiness looks only at the current count; a response popping this cycle
  // does not make room for an issue in the same cycle.
  assign wb.ld_issue_ready_o = !fifo_full && !issue_rd_busy;
  assign wb.alu_ready_o      = !wb.ld_rsp_valid_i;

  assign ld_push    = wb.ld_issue_valid_i && wb.ld_issue_ready_o;
  assign ld_pop     = wb.ld_rsp_valid_i && !fifo_empty;
  assign alu_accept = wb.alu_valid_i && wb.alu_ready_o;

  assign issue_meta = '{rd:     wb.ld_issue_rd_i,
                        funct3: wb.ld_issue_funct3_i,
                        offset: wb.ld_issue_offset_i};
  assign head       = fifo_q[rd_ptr_q];

  // Load metadata storage; contents are don't-care while the slot is empty.
  always_ff @(posedge clk) begin
    if (ld_push) begin
      fifo_q[wr_ptr_q] <= issue_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (ld_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (ld_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({ld_push, ld_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    ld_byte   = 8'h00;
    ld_half   = 16'h0000;
    ld_result = wb.ld_rsp_data_i;
    case (head.offset)
      2'd0:    ld_byte = wb.ld_rsp_data_i[7:0];
      2'd1:    ld_byte = wb.ld_rsp_data_i[15:8];
      2'd2:    ld_byte = wb.ld_rsp_data_i[23:16];
      default: ld_byte = wb.ld_rsp_data_i[31:24];
    endcase
    ld_half = head.offset[1] ? wb.ld_rsp_data_i[31:16] : wb.ld_rsp_data_i[15:0];
    case (head.funct3)
      3'b000:  ld_result = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_result = {24'h000000, ld_byte};
      3'b001:  ld_result = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_result = {16'h0000, ld_half};
      default: ld_result = wb.ld_rsp_data_i;
    endcase
  end

  // Registered write port; a popped load always wins over the ALU.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_en_q      <= 1'b0;
      wr_is_load_q <= 1'b0;
      rd_addr_q    <= 5'd0;
      wr_data_q    <= 32'd0;
    end else if (ld_pop) begin
      wr_en_q      <= (head.rd != 5'd0);
      wr_is_load_q <= 1'b1;
      rd_addr_q    <= head.rd;
      wr_data_q    <= ld_result;
    end else if (alu_accept) begin
      wr_en_q      <= (wb.alu_rd_i != 5'd0);
      wr_is_load_q <= 1'b0;
      rd_addr_q    <= wb.alu_rd_i;
      wr_data_q    <= wb.alu_data_i;
    end else begin
      wr_en_q      <= 1'b0;
      wr_is_load_q <= 1'b0;
    end
  end

  // A load's busy bit drops on the same edge the register file captures its data,
  // so decode never reads a stale value.
  always_comb begin
    busy_next = busy_q;
    if (wr_en_q && wr_is_load_q) begin
      busy_next[rd_addr_q] = 1'b0;
    end
    if (ld_push && (wb.ld_issue_rd_i != 5'd0)) begin
      busy_next[wb.ld_issue_rd_i] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_q <= 32'd0;
    end else begin
      busy_q <= busy_next;
    end
  end

  assign wb.rd_addr_o = rd_addr_q;
  assign wb.wr_en_o   = wr_en_q;
  assign wb.wr_data_o = wr_data_q;
  assign wb.hazard_o  = rs_hazard(wb.rs1_addr_i, busy_q, wr_en_q, rd_addr_q) ||
                        rs_hazard(wb.rs2_addr_i, busy_q, wr_en_q, rd_addr_q);

endmodule

// File: tb/tb_yarp_writeback.sv
// Bench for yarp_writeback: directed scenarios plus randomized traffic, all checked
// against a queue-based model of outstanding loads and the register-file write port.
module tb_yarp_writeback;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  yarp_writeback_if wb();

  yarp_writeback #(.LD_DEPTH(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wb      (wb)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  typedef struct {
    logic [4:0] rd;
    logic [2:0] f3;
    logic [1:0] off;
  } ld_t;

  ld_t         pend[$];
  logic        m_we;
  logic        m_is_load;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic [37:0] exp_q[$];

  function automatic logic [31:0] ext(input logic [2:0] f3, input logic [1:0] off,
                                      input logic [31:0] data);
    logic [31:0] v;
    case (f3)
      3'b000: begin
        v = (data >> (8 * int'(off))) & 32'hFF;
        if (v >= 32'd128) v = v - 32'd256;
      end
      3'b100: v = (data >> (8 * int'(off))) & 32'hFF;
      3'b001: begin
        v = (data >> (16 * int'(off[1]))) & 32'hFFFF;
        if (v >= 32'd32768) v = v - 32'd65536;
      end
      3'b101: v = (data >> (16 * int'(off[1]))) & 32'hFFFF;
      default: v = data;
    endcase
    return v;
  endfunction

  function automatic logic in_pend(input logic [4:0] r);
    foreach (pend[i]) if (pend[i].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_busy(input logic [4:0] r);
    return (r != 0) && (in_pend(r) || (m_we && m_is_load && m_rd == r));
  endfunction

  function automatic logic m_haz(input logic [4:0] r);
    return (r != 0) && (in_pend(r) || (m_we && m_rd == r));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    wb.ld_issue_valid_i  = 1'b0;
    wb.ld_issue_rd_i     = 5'd0;
    wb.ld_issue_funct3_i = 3'd0;
    wb.ld_issue_offset_i = 2'd0;
    wb.ld_rsp_valid_i    = 1'b0;
    wb.ld_rsp_data_i     = 32'd0;
    wb.alu_valid_i       = 1'b0;
    wb.alu_rd_i          = 5'd0;
    wb.alu_data_i        = 32'd0;
    wb.rs1_addr_i        = 5'd0;
    wb.rs2_addr_i        = 5'd0;
  endtask

  // One clock with the inputs currently driven: checks combinational outputs,
  // predicts the next write, advances the model, then checks the write port.
  task automatic cycle();
    logic       e_ready, e_alu, e_haz, push, pop;
    logic       n_we, n_is_load;
    logic [4:0] n_rd;
    logic [31:0] n_data;
    logic [37:0] e;
    ld_t        ent;
    #1;
    e_ready = (pend.size() < 2) && !m_busy(wb.ld_issue_rd_i);
    e_alu   = !wb.ld_rsp_valid_i;
    e_haz   = m_haz(wb.rs1_addr_i) || m_haz(wb.rs2_addr_i);
    chk("ld_issue_ready", {31'd0, wb.ld_issue_ready_o}, {31'd0, e_ready});
    chk("alu_ready",      {31'd0, wb.alu_ready_o},      {31'd0, e_alu});
    chk("hazard",         {31'd0, wb.hazard_o},         {31'd0, e_haz});
    push = wb.ld_issue_valid_i && e_ready;
    pop  = wb.ld_rsp_valid_i && (pend.size() > 0);
    n_we = 1'b0; n_is_load = 1'b0; n_rd = m_rd; n_data = m_data;
    if (!reset_n) begin
      n_rd = 5'd0; n_data = 32'd0;
    end else if (pop) begin
      n_we = (pend[0].rd != 0); n_is_load = 1'b1;
      n_rd = pend[0].rd; n_data = ext(pend[0].f3, pend[0].off, wb.ld_rsp_data_i);
    end else if (wb.alu_valid_i && e_alu) begin
      n_we = (wb.alu_rd_i != 0);
      n_rd = wb.alu_rd_i; n_data = wb.alu_data_i;
    end
    exp_q.push_back({n_we, n_rd, n_data});
    ent.rd = wb.ld_issue_rd_i; ent.f3 = wb.ld_issue_funct3_i; ent.off = wb.ld_issue_offset_i;
    @(posedge clk);
    if (!reset_n) begin
      pend.delete();
    end else begin
      if (pop)  void'(pend.pop_front());
      if (push) pend.push_back(ent);
    end
    m_we = n_we; m_is_load = n_is_load; m_rd = n_rd; m_data = n_data;
    @(negedge clk);
    e = exp_q.pop_front();
    chk("wr_en",   {31'd0, wb.wr_en_o}, {31'd0, e[37]});
    chk("rd_addr", {27'd0, wb.rd_addr_o}, {27'd0, e[36:32]});
    chk("wr_data", wb.wr_data_o, e[31:0]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic alu_stalled;
    logic all_clear;
    checks = 0; failures = 0;
    m_we = 1'b0; m_is_load = 1'b0; m_rd = 5'd0; m_data = 32'd0;
    reset_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // model pins
    chk("model_lb",  ext(3'b000, 2'd2, 32'h80FF7F01), 32'hFFFFFFFF);
    chk("model_lhu", ext(3'b101, 2'd2, 32'h80FF7F01), 32'h000080FF);
    chk("model_lbu", ext(3'b100, 2'd3, 32'h80FF7F01), 32'h00000080);

    // reset state
    chk("rst_wr_en",   {31'd0, wb.wr_en_o}, 32'd0);
    chk("rst_rd_addr", {27'd0, wb.rd_addr_o}, 32'd0);
    chk("rst_wr_data", wb.wr_data_o, 32'd0);
    all_clear = 1'b1;
    for (int r = 0; r < 32; r++) begin
      wb.rs1_addr_i = 5'(r); wb.rs2_addr_i = 5'(31 - r);
      #0.1;
      if (wb.hazard_o !== 1'b0) all_clear = 1'b0;
    end
    chk("rst_hazard_all", {31'd0, all_clear}, 32'd1);
    idle();
    cycle();

    // ALU write and its hazard window
    idle(); wb.alu_valid_i = 1'b1; wb.alu_rd_i = 5'd5; wb.alu_data_i = 32'hDEADBEEF;
    cycle();
    chk("alu_wr_en", {31'd0, wb.wr_en_o}, 32'd1);
    chk("alu_rd",    {27'd0, wb.rd_addr_o}, 32'd5);
    chk("alu_data",  wb.wr_data_o, 32'hDEADBEEF);
    idle(); wb.rs1_addr_i = 5'd5; #1;
    chk("alu_haz_n1", {31'd0, wb.hazard_o}, 32'd1);
    cycle();
    idle(); wb.rs1_addr_i = 5'd5; #1;
    chk("alu_haz_n2", {31'd0, wb.hazard_o}, 32'd0);
    cycle();

    // load extension and full FIFO
    idle(); wb.ld_issue_valid_i = 1'b1; wb.ld_issue_rd_i = 5'd3;
    wb.ld_issue_funct3_i = 3'b000; wb.ld_issue_offset_i = 2'd2;
    cycle();
    idle(); wb.ld_issue_valid_i = 1'b1; wb.ld_issue_rd_i = 5'd4;
    wb.ld_issue_funct3_i = 3'b101; wb.ld_issue_offset_i = 2'd2;
    cycle();
    idle(); wb.rs1_addr_i = 5'd3; wb.rs2_addr_i = 5'd4; #1;
    chk("full_ready", {31'd0, wb.ld_issue_ready_o}, 32'd0);
    chk("busy_haz",   {31'd0, wb.hazard_o}, 32'd1);
    cycle();
    idle(); wb.ld_rsp_valid_i = 1'b1; wb.ld_rsp_data_i = 32'h80FF7F01;
    cycle();
    chk("lb_rd",   {27'd0, wb.rd_addr_o}, 32'd3);
    chk("lb_data", wb.wr_data_o, 32'hFFFFFFFF);
    idle(); wb.ld_issue_valid_i = 1'b1; wb.ld_issue_rd_i = 5'd4; wb.ld_issue_funct3_i = 3'b010;
    #1;
    chk("busy_rd_blocked", {31'd0, wb.ld_issue_ready_o}, 32'd0);
    cycle();
    idle(); wb.ld_rsp_valid_i = 1'b1; wb.ld_rsp_data_i = 32'h80FF7F01;
    cycle();
    chk("lhu_rd",   {27'd0, wb.rd_addr_o}, 32'd4);
    chk("lhu_data", wb.wr_data_o, 32'h000080FF);
    idle(); wb.ld_rsp_valid_i = 1'b1; wb.ld_rsp_data_i = 32'h13579BDF;
    cycle();
    chk("stray_wr_en", {31'd0, wb.wr_en_o}, 32'd0);

    // collision: load response beats ALU
    idle(); wb.ld_issue_valid_i = 1'b1; wb.ld_issue_rd_i = 5'd6; wb.ld_issue_funct3_i = 3'b010;
    cycle();
    idle(); wb.ld_rsp_valid_i = 1'b1; wb.ld_rsp_data_i = 32'h12345678;
    wb.alu_valid_i = 1'b1; wb.alu_rd_i = 5'd7; wb.alu_data_i = 32'hA5A5A5A5;
    #1;
    chk("coll_alu_ready", {31'd0, wb.alu_ready_o}, 32'd0);
    cycle();
    chk("coll_ld_rd",   {27'd0, wb.rd_addr_o}, 32'd6);
    chk("coll_ld_data", wb.wr_data_o, 32'h12345678);
    wb.ld_rsp_valid_i = 1'b0;
    cycle();
    chk("coll_alu_rd",   {27'd0, wb.rd_addr_o}, 32'd7);
    chk("coll_alu_data", wb.wr_data_o, 32'hA5A5A5A5);

    // rd=0 load
    idle(); wb.ld_issue_valid_i = 1'b1; wb.ld_issue_rd_i = 5'd0; wb.ld_issue_funct3_i = 3'b000;
    cycle();
    idle(); wb.ld_issue_valid_i = 1'b1; wb.ld_issue_rd_i = 5'd0; #1;
    chk("rd0_not_busy", {31'd0, wb.ld_issue_ready_o}, 32'd1);
    wb.ld_issue_valid_i = 1'b0;
    wb.ld_rsp_valid_i = 1'b1; wb.ld_rsp_data_i = 32'hFFFFFFFF;
    cycle();
    chk("rd0_wr_en", {31'd0, wb.wr_en_o}, 32'd0);

    // reset with two loads outstanding
    idle(); wb.ld_issue_valid_i = 1'b1; wb.ld_issue_rd_i = 5'd9;
    cycle();
    idle(); wb.ld_issue_valid_i = 1'b1; wb.ld_issue_rd_i = 5'd10;
    cycle();
    idle(); reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    idle(); wb.rs1_addr_i = 5'd9; wb.rs2_addr_i = 5'd10; wb.ld_issue_rd_i = 5'd9; #1;
    chk("post_rst_hazard", {31'd0, wb.hazard_o}, 32'd0);
    chk("post_rst_ready",  {31'd0, wb.ld_issue_ready_o}, 32'd1);
    cycle();
    idle(); wb.ld_rsp_valid_i = 1'b1; wb.ld_rsp_data_i = 32'hCAFEF00D;
    cycle();
    chk("post_rst_wr_en", {31'd0, wb.wr_en_o}, 32'd0);

    // randomized traffic
    alu_stalled = 1'b0;
    idle();
    for (int n = 0; n < 2000; n++) begin
      reset_n              = ($urandom_range(0, 99) != 0);
      wb.ld_issue_valid_i  = ($urandom_range(0, 1) == 1);
      wb.ld_issue_rd_i     = 5'($urandom_range(0, 7));
      wb.ld_issue_funct3_i = 3'($urandom_range(0, 7));
      wb.ld_issue_offset_i = 2'($urandom_range(0, 3));
      wb.ld_rsp_valid_i    = ($urandom_range(0, 9) < 4);
      wb.ld_rsp_data_i     = $urandom;
      if (!alu_stalled) begin
        wb.alu_valid_i = ($urandom_range(0, 1) == 1);
        wb.alu_rd_i    = 5'($urandom_range(0, 7));
        wb.alu_data_i  = $urandom;
      end
      wb.rs1_addr_i = 5'($urandom_range(0, 7));
      wb.rs2_addr_i = 5'($urandom_range(0, 7));
      alu_stalled = wb.alu_valid_i && wb.ld_rsp_valid_i && reset_n;
      cycle();
    end
    reset_n = 1'b1;
    idle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/yarp_writeback.md
Name: yarp_writeback

Overview:
- Retire stage that drives the register-file write port: rd address, write enable, write data.
- Merges two result sources: single-cycle ALU results and variable-latency, in-order load responses.
- For loads, it performs byte/halfword extraction and sign/zero extension.
- A busy-register scoreboard drives hazard_o, which decode uses to stall until a pending load's data is architecturally visible.

Parameters:
- LD_DEPTH, 2, max outstanding loads; depth of the load-metadata FIFO (power of 2, >=1).

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
ld_issue_valid_i  in  1  load issued to memory this cycle
ld_issue_ready_o  out  1  load may be issued
ld_issue_rd_i  in  5  load destination register
ld_issue_funct3_i  in  3  load type (RV32I funct3)
ld_issue_offset_i  in  2  byte offset addr[1:0]
ld_rsp_valid_i  in  1  load response data valid (no backpressure)
ld_rsp_data_i  in  32  raw aligned memory word
alu_valid_i  in  1  ALU result valid
alu_ready_o  out  1  ALU result accepted
alu_rd_i  in  5  ALU destination register
alu_data_i  in  32  ALU result
rd_addr_o  out  5  register-file write address
wr_en_o  out  1  register-file write enable
wr_data_o  out  32  register-file write data
rs1_addr_i  in  5  decode source 1
rs2_addr_i  in  5  decode source 2
hazard_o  out  1  stall decode

Behaviour:
- Reset: one clock, clk; reset is synchronous, active-low on reset_n. While reset_n=0 at a clk edge:
  - FIFO empties; all busy bits clear.
  - rd_addr_o=0, wr_en_o=0, wr_data_o=0.
- Reset mid-operation discards outstanding loads. Responses arriving after reset with the FIFO empty are ignored.
- Load issue:
  - Handshake: ld_issue_valid_i & ld_issue_ready_o.
  - The handshake pushes {rd, funct3, offset} into the FIFO.
  - ld_issue_ready_o = (count < LD_DEPTH) & !(busy[ld_issue_rd_i] & ld_issue_rd_i!=0). It is computed from the current count; a same-cycle pop does not free a slot.
  - Issue with rd!=0 sets busy[rd] at that edge.
- Load response:
  - ld_rsp_valid_i pops the FIFO head in the same cycle.
  - Response with the FIFO empty: ignored; no write, no state change.
  - Simultaneous push and pop are allowed; count is unchanged.
- Extension by funct3:
  - 000 LB: byte at offset, sign-extended.
  - 100 LBU: byte at offset, zero-extended.
  - 001 LH: half at offset[1], sign-extended.
  - 101 LHU: half at offset[1], zero-extended.
  - 010 and all other codes: full word.
- Arbitration: load response has priority.
  - alu_ready_o = !ld_rsp_valid_i (combinational).
  - ALU result is accepted when alu_valid_i & alu_ready_o. A stalled ALU source holds its inputs stable.
- Write port (registered, latency 1): for the accepted source in cycle N, cycle N+1 shows:
  - rd_addr_o = rd, wr_data_o = result.
  - wr_en_o = (rd != 0). rd==0 results are dropped; wr_en_o stays 0.
  - Cycles with no accepted source give wr_en_o=0; rd_addr_o and wr_data_o hold their last values.
- Scoreboard:
  - busy[rd] of a load clears at the edge ending the cycle in which its wr_en_o=1, i.e. the same edge on which the register file captures the data.
  - busy[0] is always 0.
- Hazard (combinational): hazard_o = 1 when, for either source register rs (rs1_addr_i or rs2_addr_i) with rs != 0:
  - busy[rs] = 1, or
  - wr_en_o = 1 and rd_addr_o = rs.

Test Plan:
- Reset, then idle: all outputs 0; hazard_o=0 for any rs.
- ALU rd=5, data 0xDEADBEEF in cycle N: cycle N+1 shows wr_en_o=1, rd_addr_o=5, wr_data_o=0xDEADBEEF; rs1=5 gives hazard_o=1 in N+1, 0 in N+2.
- Load extension, issue LB rd=3 offset=2, LHU rd=4 offset=2, response data 0x80FF7F01 for each:
  - LB writes 0xFFFFFFFF.
  - LHU writes 0x000080FF.
  - busy[3] and busy[4] set until their writes.
- Collision: ld_rsp_valid_i and alu_valid_i both high:
  - alu_ready_o=0 and the load is written first.
  - The ALU is accepted the next cycle and written one cycle later.
- Full FIFO (LD_DEPTH=2):
  - Two loads issued make ld_issue_ready_o=0.
  - A third load to a busy rd stays blocked after one slot frees.
  - A stray response with the FIFO empty produces no write.
- rd=0 handling:
  - A load with rd=0 gives no busy and no wr_en_o.
  - Asserting reset_n=0 with 2 loads outstanding clears busy bits and drops later responses.
